pc_gen: RTL and testbench

//  Parametrised program-counter generator feeding the fetch unit. Holds the architectural PC,

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_next_sel.sv | 52 +++++
 rtl/pc_gen.sv | 97 +++++++++
 tb/tb_pc_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter generator.
// Imported by pc_next_sel and pc_gen.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TRAP  = 2'd0,
    REDIR = 2'd1,
    SEQ   = 2'd2,
    HOLD  = 2'd3
  } src_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h8000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: trap > redirect > sequential advance > hold, with target
// alignment and a flag for targets whose forced-low bits were set.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter int               INST_BYTES = 4,
  parameter logic [XLEN-1:0]  TRAP_VEC   = XLEN'(DEFAULT_TRAP_VEC)
) (
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            trap_vld,
  input  logic            trap_tgt_vld,
  input  logic [XLEN-1:0] trap_tgt,
  input  logic            redir_vld,
  input  logic [XLEN-1:0] redir_tgt,
  output logic [XLEN-1:0] next_pc,
  output src_t            src,
  output logic            misalign
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

  logic [XLEN-1:0] target;
  logic            load;

  always_comb begin
    target   = '0;
    load     = 1'b0;
    next_pc  = pc;
    src      = HOLD;
    misalign = 1'b0;
    if (trap_vld) begin
      load   = 1'b1;
      src    = TRAP;
      target = trap_tgt_vld ? trap_tgt : TRAP_VEC;
    end else if (redir_vld) begin
      load   = 1'b1;
      src    = REDIR;
      target = redir_tgt;
    end else if (advance) begin
      src     = SEQ;
      next_pc = pc + STEP;
    end
    if (load) begin
      next_pc  = target & ALIGN_MASK;
      misalign = |(target & ~ALIGN_MASK);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT control plus the architectural PC register.
// Define PC_TRACE_EN for a simulation-only trace of fires and redirects.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(DEFAULT_RESET_PC),
  parameter int               INST_BYTES = 4,
  parameter logic [XLEN-1:0]  TRAP_VEC   = XLEN'(DEFAULT_TRAP_VEC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            redir_vld,
  input  logic [XLEN-1:0] redir_tgt,
  input  logic            trap_vld,
  input  logic            trap_tgt_vld,
  input  logic [XLEN-1:0] trap_tgt,
  input  logic            halt_req,
  input  logic            resume,
  output logic            halted,
  output logic            misalign
);

  // Handshake: pc is offered while pc_valid; a fire is pc_valid & pc_ready on a
  // rising edge. With pc_ready low, pc stays put unless a trap/redirect loads it.
  state_t          state, state_next;
  logic            fire;
  logic            advance;
  logic [XLEN-1:0] sel_next;
  src_t            sel_src;
  logic            sel_misalign;

  assign pc_valid = (state == RUN);
  assign halted   = (state == HALT);
  assign fire     = pc_valid & pc_ready;
  // A fire coinciding with halt_req is dropped: the halt wins and pc does not move.
  assign advance  = fire & ~halt_req;

  pc_next_sel #(
    .XLEN       (XLEN),
    .INST_BYTES (INST_BYTES),
    .TRAP_VEC   (TRAP_VEC)
  ) u_next_sel (
    .pc           (pc),
    .advance      (advance),
    .trap_vld     (trap_vld),
    .trap_tgt_vld (trap_tgt_vld),
    .trap_tgt     (trap_tgt),
    .redir_vld    (redir_vld),
    .redir_tgt    (redir_tgt),
    .next_pc      (sel_next),
    .src          (sel_src),
    .misalign     (sel_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (halt_req) state_next = HALT;
      HALT:    if (resume && !halt_req) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= sel_misalign;
      if (sel_src != HOLD) pc <= sel_next;
    end
  end

`ifdef PC_TRACE_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (fire) $display("pc_gen: fire pc=%h", pc);
      if (sel_src == TRAP || sel_src == REDIR)
        $display("pc_gen: %s old=%h new=%h", sel_src.name(), pc, sel_next);
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the PC rules.
module tb_pc_gen;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] TRAP_VEC   = 32'h8000_0100;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready     = 1'b0;
  logic        redir_vld    = 1'b0;
  logic [31:0] redir_tgt    = '0;
  logic        trap_vld     = 1'b0;
  logic        trap_tgt_vld = 1'b0;
  logic [31:0] trap_tgt     = '0;
  logic        halt_req     = 1'b0;
  logic        resume       = 1'b0;
  logic        halted;
  logic        misalign;

  pc_gen #(
    .XLEN       (32),
    .RESET_PC   (RESET_PC),
    .INST_BYTES (INST_BYTES),
    .TRAP_VEC   (TRAP_VEC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .pc_ready     (pc_ready),
    .redir_vld    (redir_vld),
    .redir_tgt    (redir_tgt),
    .trap_vld     (trap_vld),
    .trap_tgt_vld (trap_tgt_vld),
    .trap_tgt     (trap_tgt),
    .halt_req     (halt_req),
    .resume       (resume),
    .halted       (halted),
    .misalign     (misalign)
  );

  int checks = 0;
  int passed = 0;

  // reference model: mode 0 = boot, 1 = running, 2 = halted
  logic [31:0] m_pc  = RESET_PC;
  int          m_mode = 0;
  logic        m_mis = 1'b0;

  function automatic logic [31:0] m_align(input logic [31:0] t);
    return t - (t % INST_BYTES);
  endfunction

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_mode = 0;
    m_mis  = 1'b0;
  endtask

  task automatic idle_inputs();
    pc_ready     = 1'b0;
    redir_vld    = 1'b0;
    redir_tgt    = '0;
    trap_vld     = 1'b0;
    trap_tgt_vld = 1'b0;
    trap_tgt     = '0;
    halt_req     = 1'b0;
    resume       = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs, then step the DUT
  // and land 1ns after the rising edge.
  task automatic tick();
    logic [31:0] tgt;
    logic        load;
    tgt  = '0;
    load = 1'b0;
    if (trap_vld) begin
      load = 1'b1;
      tgt  = trap_tgt_vld ? trap_tgt : TRAP_VEC;
    end else if (redir_vld) begin
      load = 1'b1;
      tgt  = redir_tgt;
    end
    m_mis = load && ((tgt % INST_BYTES) != 0);
    if (load) m_pc = m_align(tgt);
    else if (m_mode == 1 && pc_ready && !halt_req) m_pc = m_pc + 32'(INST_BYTES);
    case (m_mode)
      0: m_mode = 1;
      1: if (halt_req) m_mode = 2;
      default: if (resume && !halt_req) m_mode = 1;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({pc, pc_valid, halted, misalign} !== {32'h8000_0000, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset: pc=%h v=%b h=%b m=%b, expected pc=80000000 v=0 h=0 m=0",
               pc, pc_valid, halted, misalign);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h8000_0000;
    exp_seq[1] = 32'h8000_0004;
    exp_seq[2] = 32'h8000_0008;
    pc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({pc, pc_valid, halted, misalign} !== {exp_seq[i], 1'b1, 1'b0, 1'b0} || pc !== m_pc)
        $display("FAIL seq[%0d]: pc=%h v=%b h=%b m=%b, expected pc=%h v=1 h=0 m=0",
                 i, pc, pc_valid, halted, misalign, exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_stall();
    pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h8000_0008 || pc_valid !== 1'b1)
        $display("FAIL stall[%0d]: pc=%h v=%b, expected pc=80000008 v=1", i, pc, pc_valid);
      else passed++;
    end
  endtask

  task automatic test_redirect();
    pc_ready  = 1'b1;
    redir_vld = 1'b1;
    redir_tgt = 32'h8000_1000;
    tick();
    checks++;
    if (pc !== 32'h8000_1000 || misalign !== 1'b0 || pc !== m_pc)
      $display("FAIL redirect_fire: pc=%h m=%b, expected pc=80001000 m=0", pc, misalign);
    else passed++;
    trap_vld     = 1'b1;
    trap_tgt_vld = 1'b0;
    trap_tgt     = 32'h1234_5678;
    redir_tgt    = 32'h8000_2000;
    tick();
    checks++;
    if (pc !== 32'h8000_0100 || pc !== m_pc)
      $display("FAIL trap_priority: pc=%h, expected pc=80000100", pc);
    else passed++;
    trap_tgt_vld = 1'b1;
    trap_tgt     = 32'h8000_0400;
    tick();
    checks++;
    if (pc !== 32'h8000_0400 || pc !== m_pc)
      $display("FAIL trap_tgt: pc=%h, expected pc=80000400", pc);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_misalign();
    redir_vld = 1'b1;
    redir_tgt = 32'h8000_2002;
    tick();
    checks++;
    if (pc !== 32'h8000_2000 || misalign !== 1'b1)
      $display("FAIL misalign_set: pc=%h m=%b, expected pc=80002000 m=1", pc, misalign);
    else passed++;
    idle_inputs();
    tick();
    checks++;
    if (pc !== 32'h8000_2000 || misalign !== 1'b0)
      $display("FAIL misalign_pulse: pc=%h m=%b, expected pc=80002000 m=0", pc, misalign);
    else passed++;
  endtask

  task automatic test_halt();
    pc_ready = 1'b1;
    halt_req = 1'b1;
    tick();
    checks++;
    if ({pc, pc_valid, halted} !== {32'h8000_2000, 1'b0, 1'b1})
      $display("FAIL halt_enter: pc=%h v=%b h=%b, expected pc=80002000 v=0 h=1",
               pc, pc_valid, halted);
    else passed++;
    halt_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({pc, pc_valid, halted} !== {m_pc, 1'b0, 1'b1} || pc !== 32'h8000_2000)
        $display("FAIL halt_hold[%0d]: pc=%h v=%b h=%b, expected pc=80002000 v=0 h=1",
                 i, pc, pc_valid, halted);
      else passed++;
    end
    redir_vld = 1'b1;
    redir_tgt = 32'h8000_3000;
    tick();
    checks++;
    if ({pc, halted} !== {32'h8000_3000, 1'b1})
      $display("FAIL halt_redirect: pc=%h h=%b, expected pc=80003000 h=1", pc, halted);
    else passed++;
    redir_vld = 1'b0;
    halt_req  = 1'b1;
    resume    = 1'b1;
    tick();
    checks++;
    if ({pc_valid, halted} !== 2'b01)
      $display("FAIL halt_resume_clash: v=%b h=%b, expected v=0 h=1", pc_valid, halted);
    else passed++;
    halt_req = 1'b0;
    tick();
    checks++;
    if ({pc, pc_valid, halted} !== {32'h8000_3000, 1'b1, 1'b0})
      $display("FAIL resume: pc=%h v=%b h=%b, expected pc=80003000 v=1 h=0",
               pc, pc_valid, halted);
    else passed++;
    resume = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h8000_3004 || pc !== m_pc)
      $display("FAIL resume_fire: pc=%h, expected pc=80003004", pc);
    else passed++;
  endtask

  task automatic test_wrap();
    redir_vld = 1'b1;
    redir_tgt = 32'hFFFF_FFFC;
    tick();
    redir_vld = 1'b0;
    pc_ready  = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h0000_0000 || pc !== m_pc)
      $display("FAIL wrap: pc=%h, expected pc=00000000", pc);
    else passed++;
  endtask

  task automatic test_async_reset();
    pc_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({pc, pc_valid, halted, misalign} !== {32'h8000_0000, 1'b0, 1'b0, 1'b0})
      $display("FAIL async_reset: pc=%h v=%b h=%b m=%b, expected pc=80000000 v=0 h=0 m=0",
               pc, pc_valid, halted, misalign);
    else passed++;
    #1 rst = 1'b0;
    tick();
    checks++;
    if ({pc, pc_valid} !== {32'h8000_0000, 1'b1})
      $display("FAIL post_reset_boot: pc=%h v=%b, expected pc=80000000 v=1", pc, pc_valid);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      pc_ready     = ($urandom_range(0, 3) != 0);
      redir_vld    = ($urandom_range(0, 9) == 0);
      trap_vld     = ($urandom_range(0, 19) == 0);
      trap_tgt_vld = $urandom_range(0, 1) == 1;
      r            = $urandom;
      redir_tgt    = $urandom_range(0, 1) == 1 ? r : (r & 32'hFFFF_FFFC);
      r            = $urandom;
      trap_tgt     = $urandom_range(0, 1) == 1 ? r : (r & 32'hFFFF_FFFC);
      halt_req     = ($urandom_range(0, 29) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if ({pc, pc_valid, halted, misalign} !== {m_pc, m_mode == 1, m_mode == 2, m_mis})
        $display("FAIL random[%0d]: pc=%h v=%b h=%b m=%b, expected pc=%h v=%b h=%b m=%b",
                 i, pc, pc_valid, halted, misalign,
                 m_pc, m_mode == 1, m_mode == 2, m_mis);
      else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
